// File: rtl/tmds_encoder_if.sv
// tmds_encoder_if: pixel-side inputs (de, data, c0, c1) and encoded symbol output (tmds)
interface tmds_encoder_if;
  logic de;
  logic [7:0] data;
  logic c0;
  logic c1;
  logic [9:0] tmds;
  modport master(output de, data, c0, c1, input tmds);
  modport slave(input de, data, c0, c1, output tmds);
endinterface

// File: rtl/tmds_encoder.sv
// tmds_encoder: DVI TMDS channel encoder, 8b/10b with running disparity, 2-clock latency
// CLOCK_PX: pixel clock; RESET: async active-high; bus: de/data/c0/c1 in, tmds symbol out (bit 0 first)
module tmds_encoder #(
  parameter logic [9:0] CTRL_TOKEN_RESET = 10'b1101010100
) (
  input logic CLOCK_PX,
  input logic RESET,
  tmds_encoder_if.slave bus
);
  logic [3:0] n1d, n1q;
  logic use_xnor, de_q, c0_q, c1_q, inv, case_a, case_b;
  logic [8:0] qm, qm_q;
  logic signed [4:0] cnt, cnt_nxt, diff;
  logic [9:0] tmds_q, tmds_nxt, token;
  always_comb begin
    n1d = '0;
    for (int i = 0; i < 8; i++) n1d = n1d + {3'b0, bus.data[i]};
    use_xnor = n1d > 4'd4 || (n1d == 4'd4 && !bus.data[0]);
    qm[0] = bus.data[0];
    for (int i = 1; i < 8; i++) qm[i] = qm[i-1] ^ bus.data[i] ^ use_xnor;
    qm[8] = !use_xnor;
  end
  // diff = n1q - n0q = 2*n1q - 8, wraps correctly modulo 32
  always_comb begin
    n1q = '0;
    for (int i = 0; i < 8; i++) n1q = n1q + {3'b0, qm_q[i]};
    diff = $signed({n1q, 1'b0}) - 5'sd8;
    case_a = cnt == 5'sd0 || n1q == 4'd4;
    case_b = (cnt > 5'sd0 && n1q > 4'd4) || (cnt < 5'sd0 && n1q < 4'd4);
    inv = case_a ? !qm_q[8] : case_b;
    token = c1_q ? (c0_q ? 10'b1010101011 : 10'b0101010100)
                 : (c0_q ? 10'b0010101011 : 10'b1101010100);
    tmds_nxt = de_q ? {inv, qm_q[8], inv ? ~qm_q[7:0] : qm_q[7:0]} : token;
    cnt_nxt = !de_q ? 5'sd0
            : case_a ? (qm_q[8] ? cnt + diff : cnt - diff)
            : case_b ? cnt - diff + (qm_q[8] ? 5'sd2 : 5'sd0)
            : cnt + diff - (qm_q[8] ? 5'sd0 : 5'sd2);
  end
  always_ff @(posedge CLOCK_PX or posedge RESET)
    if (RESET) begin
      de_q <= 1'b0;
      c0_q <= 1'b0;
      c1_q <= 1'b0;
      qm_q <= '0;
      cnt <= '0;
      tmds_q <= CTRL_TOKEN_RESET;
    end else begin
      de_q <= bus.de;
      c0_q <= bus.c0;
      c1_q <= bus.c1;
      qm_q <= qm;
      cnt <= cnt_nxt;
      tmds_q <= tmds_nxt;
    end
  assign bus.tmds = tmds_q;
endmodule

// File: doc/tmds_encoder.md
# tmds_encoder

Single-channel DVI 1.0 TMDS encoder: converts one 8-bit colour component plus two control bits into a 10-bit DC-balanced TMDS symbol per pixel clock. Three instances, one each for blue, green and red, sit between `video_generator` and the serializer inside `tmds_tx`. The hsync/vsync pair drives c0/c1 on the blue instance; the green and red instances tie them to 0. The block is a two-stage pipeline with a running-disparity counter.

## Interface
- `CTRL_TOKEN_RESET`, default 10'b1101010100: the value `tmds` takes during reset. This is the c1c0=00 token.
- `CLOCK_PX`  in  1  Pixel clock. All logic is on the rising edge.
- `RESET`  in  1  Asynchronous, active-high reset.
- `de`  in  1  Video data enable. 1 selects pixel data; 0 selects the control period.
- `data`  in  8  Colour component. Sampled only when `de`=1.
- `c0`  in  1  Control bit 0. Sampled only when `de`=0.
- `c1`  in  1  Control bit 1. Sampled only when `de`=0.
- `tmds`  out  10  Encoded symbol. Bit 0 is transmitted first.

## Operation
- **Stage 1 (registered):**
  - Register `de`, `c0` and `c1`.
  - Compute n1d = popcount(`data`), 4 bits.
  - Select the transition-minimised form q_m[8:0]:
    - Use XNOR if n1d>4, or if n1d==4 and data[0]==0: q_m[0]=d[0]; q_m[i]=q_m[i-1] XNOR d[i]; q_m[8]=0.
    - Otherwise use XOR: q_m[i]=q_m[i-1] XOR d[i]; q_m[8]=1.
  - Register q_m.
- **Stage 2 (registered output):**
  - Compute n1q = popcount(q_m[7:0]) and n0q = 8 − n1q.
  - Running disparity `cnt` is a 5-bit two's-complement register. It never overflows for any input sequence.
- **Control period (de=0):** cnt ← 0. `tmds` is selected by {c1,c0}:
  - 00 → 1101010100
  - 01 → 0010101011
  - 10 → 0101010100
  - 11 → 1010101011
- **Data period (de=1), case A — cnt==0 or n1q==n0q:**
  - tmds = {~q_m[8], q_m[8], q_m[8] ? q_m[7:0] : ~q_m[7:0]}.
  - If q_m[8]=1: cnt += n1q−n0q. Otherwise: cnt += n0q−n1q.
- **Data period, case B — (cnt>0 and n1q>n0q) or (cnt<0 and n0q>n1q):**
  - tmds = {1, q_m[8], ~q_m[7:0]}.
  - cnt += 2·q_m[8] + n0q − n1q.
- **Data period, case C — all other data cases:**
  - tmds = {0, q_m[8], q_m[7:0]}.
  - cnt += n1q − n0q − 2·(~q_m[8]).
- **Signedness:** all arithmetic is signed, with operands sign-extended to 5 bits before the add.
- **Case precedence:** A is checked first, then B, else C. Exactly one case applies per cycle.
- **Reset:** asserting `RESET` immediately (asynchronously) sets:
  - `tmds` = CTRL_TOKEN_RESET
  - cnt = 0
  - all stage-1 registers to 0 (de=0, c=00, q_m=0)
- **Reset mid-operation:** any in-flight symbols are discarded.
  - After release, the first two output symbols are 1101010100, because the pipeline was flushed to de=0, c=00.
  - Encoding then resumes with cnt=0.
- **Transition de 1→0:** the disparity history is discarded. The next data period starts from cnt=0.
- **Flow control:** none, and no backpressure. One symbol is produced every clock.

## Timing
- Latency is 2 clocks: inputs sampled at edge N appear on `tmds` after edge N+1 and are valid through edge N+2.
- `de`, `c0`, `c1` and `data` are delayed identically, so data and control stay aligned across de edges with no gap or overlap.
- Throughput is 1 symbol per clock.
- Stage 2 critical path: popcount, 5-bit compare and add. It must meet 150 MHz (the 1080p pixel clock) on Spartan-6 at -2 speed grade.
- `tmds` comes directly from a flop, with no combinational path from inputs to output.

## Test plan
- **Reset value:** assert `RESET` mid-stream → `tmds`=1101010100 in the same cycle, without waiting for a clock edge. Release with de=0, c=00 → output stays 1101010100.
- **Control tokens:** de=0, {c1,c0}=01,10,11,00 on successive clocks → 0010101011, 0101010100, 1010101011, 1101010100 appear 2 clocks later, in order.
- **Disparity run from cnt=0:** de=1, data=0x00 twice.
  - First symbol: 0100000000, cnt=−8 (case A).
  - Second symbol: 1111111111, cnt=+2 (case B).
- **XNOR path:** after a control period, de=1 data=0xFF → 1000000000, with cnt=−8 afterwards.
- **Disparity reset on de drop:** data=0x00, then de=0 for one clock, then data=0x00 → the second data symbol is again 0100000000, proving cnt was cleared.
- **Random soak:** 10^6 random de/data/c cycles compared against a reference-model encoder and decoder.
  - Output must equal the model.
  - Decoded data must equal the input.
  - cnt must stay within [−16,+15].
  - Over every data run, |Σ(ones−zeros)| must remain bounded by 20.
